// File: rtl/alu_ex_pkg.sv
// Shared definitions for the execute stage: opcode map, flag bit positions
// and the sequencing state encoding.
package alu_ex_pkg;

    // Opcodes 5'd21..5'd31 are unassigned and execute as illegal ops.
    localparam logic [4:0] OP_NOP = 5'd0;
    localparam logic [4:0] OP_ADD = 5'd1;
    localparam logic [4:0] OP_ADC = 5'd2;
    localparam logic [4:0] OP_SUB = 5'd3;
    localparam logic [4:0] OP_SBB = 5'd4;
    localparam logic [4:0] OP_INC = 5'd5;
    localparam logic [4:0] OP_DEC = 5'd6;
    localparam logic [4:0] OP_CMP = 5'd7;
    localparam logic [4:0] OP_AND = 5'd8;
    localparam logic [4:0] OP_OR  = 5'd9;
    localparam logic [4:0] OP_XOR = 5'd10;
    localparam logic [4:0] OP_NOT = 5'd11;
    localparam logic [4:0] OP_MOV = 5'd12;
    localparam logic [4:0] OP_SHL = 5'd13;
    localparam logic [4:0] OP_SHR = 5'd14;
    localparam logic [4:0] OP_SAR = 5'd15;
    localparam logic [4:0] OP_ROL = 5'd16;
    localparam logic [4:0] OP_ROR = 5'd17;
    localparam logic [4:0] OP_MUL = 5'd18;
    localparam logic [4:0] OP_LD  = 5'd19;
    localparam logic [4:0] OP_ST  = 5'd20;

    // flag_ex is packed {Z,C,N,V}
    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 0;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/alu_ex_mul.sv
// Iterative unsigned shift-add multiplier. One partial product per cycle,
// WIDTH cycles after start. A down-counter tracks remaining iterations; done
// is raised during the final iteration and product carries the value that
// iteration produces, so the consumer can capture it on the same edge.
module alu_ex_mul
    import alu_ex_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH:0]   sum;

    // Add the multiplicand into the upper half when the current multiplier bit is set.
    always_comb begin
        sum = {1'b0, hi_q} + {1'b0, (lo_q[0] ? mcand_q : '0)};
    end

    assign product = {sum, lo_q[WIDTH-1:1]};
    assign done    = busy && (cnt_q == '0);

    // Product register: load operands on start, shift right one place per iteration.
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            busy    <= 1'b0;
        end else if (abort) begin
            busy    <= 1'b0;
        end else if (start) begin
            mcand_q <= a;
            hi_q    <= '0;
            lo_q    <= b;
            cnt_q   <= CW'(WIDTH - 1);
            busy    <= 1'b1;
        end else if (busy) begin
            hi_q    <= sum[WIDTH:1];
            lo_q    <= {sum[0], lo_q[WIDTH-1:1]};
            cnt_q   <= cnt_q - 1'b1;
            if (cnt_q == '0) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_ex_stage.sv
// Execute stage: registered WIDTH-bit ALU with persistent {Z,C,N,V} flags,
// valid/ready handshakes on both sides and an optional iterative multiplier.
// Build option: define ALU_MUL_EN to execute MUL through alu_ex_mul;
// without it MUL is reported as an illegal opcode.
//
//  state | meaning
//  IDLE  | ready for a new op (subject to output backpressure)
//  MUL   | multiplier iterating, input side stalled
module alu_ex_stage
    import alu_ex_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int RW_BITS = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [4:0]         op_dec,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [WIDTH-1:0]   data_in,
    input  logic               mem_en_dec,
    input  logic               mem_rw_dec,
    input  logic               mem_mux_sel_dec,
    input  logic [RW_BITS-1:0] RW_dec,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   ans_ex,
    output logic [WIDTH-1:0]   ans_hi_ex,
    output logic [3:0]         flag_ex,
    output logic               illegal_ex,
    output logic [WIDTH-1:0]   data_out,
    output logic [WIDTH-1:0]   B_Bypass,
    output logic               mem_en_ex,
    output logic               mem_rw_ex,
    output logic               mem_mux_sel_ex,
    output logic [RW_BITS-1:0] RW_ex,
    output logic               busy
);

    localparam int M  = WIDTH - 1;
    localparam int SW = $clog2(WIDTH);

    state_t state_q, state_d;

    logic accept;
    logic is_mul;
    logic mul_done;
    logic [2*WIDTH-1:0] mul_product;

    logic [SW-1:0]  sh;
    logic [SW:0]    inv_sh;
    logic [WIDTH-1:0] add_b, sub_b;
    logic           add_ci, sub_bi;
    logic [WIDTH:0] add_r, sub_r;
    logic           add_v, sub_v;
    logic [WIDTH:0] shl_t, shr_t;
    logic signed [WIDTH:0] sar_t;
    logic [WIDTH-1:0] rol_r, ror_r;

    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] alu_ans;
    logic [3:0]       alu_flags;
    logic             alu_ill;
    logic             c_f, v_f, upd;

    assign in_ready = !reset && (state_q == IDLE) && (!out_valid || out_ready) && !flush;
    assign accept   = in_valid && in_ready;

`ifdef ALU_MUL_EN
    logic [WIDTH-1:0]   pend_data, pend_b;
    logic               pend_me, pend_mr, pend_mm;
    logic [RW_BITS-1:0] pend_rw;

    assign is_mul = (op_dec == OP_MUL);

    alu_ex_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (accept && is_mul),
        .abort   (flush),
        .a       (A),
        .b       (B),
        .busy    (busy),
        .done    (mul_done),
        .product (mul_product)
    );

    // Side-band fields of a MUL wait here until the product is ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_data <= '0;
            pend_b    <= '0;
            pend_me   <= 1'b0;
            pend_mr   <= 1'b0;
            pend_mm   <= 1'b0;
            pend_rw   <= '0;
        end else if (accept && is_mul) begin
            pend_data <= data_in;
            pend_b    <= B;
            pend_me   <= mem_en_dec;
            pend_mr   <= mem_rw_dec;
            pend_mm   <= mem_mux_sel_dec;
            pend_rw   <= RW_dec;
        end
    end
`else
    assign is_mul      = 1'b0;
    assign busy        = 1'b0;
    assign mul_done    = 1'b0;
    assign mul_product = '0;
`endif

    // Operand conditioning shared by the add/sub families (carry-in, INC/DEC constants).
    always_comb begin
        add_b  = B;
        add_ci = 1'b0;
        sub_b  = B;
        sub_bi = 1'b0;
        case (op_dec)
            OP_ADC:  add_ci = flag_ex[FLAG_C];
            OP_INC:  add_b  = WIDTH'(1);
            OP_SBB:  sub_bi = flag_ex[FLAG_C];
            OP_DEC:  sub_b  = WIDTH'(1);
            default: ;
        endcase
    end

    assign add_r = {1'b0, A} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_ci};
    assign sub_r = {1'b0, A} - {1'b0, sub_b} - {{WIDTH{1'b0}}, sub_bi};
    assign add_v = (A[M] == add_b[M]) && (add_r[M] != A[M]);
    assign sub_v = (A[M] != sub_b[M]) && (sub_r[M] != A[M]);

    // Shifts carry one spare bit so the last bit shifted out lands in a fixed position.
    assign sh     = B[SW-1:0];
    assign inv_sh = (SW+1)'(WIDTH) - {1'b0, sh};
    assign shl_t  = {1'b0, A} << sh;
    assign shr_t  = {A, 1'b0} >> sh;
    assign sar_t  = $signed({A, 1'b0}) >>> sh;
    assign rol_r  = (A << sh) | (A >> inv_sh);
    assign ror_r  = (A >> sh) | (A << inv_sh);

    // Single-cycle result, flag update and illegal-op decode.
    always_comb begin
        res     = '0;
        c_f     = 1'b0;
        v_f     = 1'b0;
        upd     = 1'b1;
        alu_ill = 1'b0;
        case (op_dec)
            OP_NOP: upd = 1'b0;
            OP_ADD, OP_ADC, OP_INC: begin
                res = add_r[M:0];
                c_f = add_r[WIDTH];
                v_f = add_v;
            end
            OP_SUB, OP_SBB, OP_DEC, OP_CMP: begin
                res = sub_r[M:0];
                c_f = sub_r[WIDTH];
                v_f = sub_v;
            end
            OP_AND: res = A & B;
            OP_OR:  res = A | B;
            OP_XOR: res = A ^ B;
            OP_NOT: res = ~A;
            OP_MOV: begin
                res = B;
                upd = 1'b0;
            end
            OP_SHL: begin
                res = shl_t[M:0];
                c_f = shl_t[WIDTH];
            end
            OP_SHR: begin
                res = shr_t[WIDTH:1];
                c_f = shr_t[0];
            end
            OP_SAR: begin
                res = sar_t[WIDTH:1];
                c_f = sar_t[0];
            end
            OP_ROL: begin
                res = rol_r;
                c_f = (sh != '0) && rol_r[0];
            end
            OP_ROR: begin
                res = ror_r;
                c_f = (sh != '0) && ror_r[M];
            end
            OP_LD, OP_ST: begin
                res = add_r[M:0];
                upd = 1'b0;
            end
`ifdef ALU_MUL_EN
            OP_MUL: upd = 1'b0;
`endif
            default: begin
                alu_ill = 1'b1;
                upd     = 1'b0;
            end
        endcase

        // CMP reports flags of A-B but passes A through as its result.
        alu_ans = (op_dec == OP_CMP) ? A : res;

        alu_flags = flag_ex;
        if (upd) begin
            alu_flags[FLAG_Z] = (res == '0);
            alu_flags[FLAG_C] = c_f;
            alu_flags[FLAG_N] = res[M];
            alu_flags[FLAG_V] = v_f;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: enter MUL on a multiply accept, leave on the final iteration or flush.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && is_mul) state_d = MUL;
            MUL:     if (mul_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
        end
    end

    // Output register: load on single-cycle accept or multiplier completion, hold under backpressure.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid      <= 1'b0;
            ans_ex         <= '0;
            ans_hi_ex      <= '0;
            flag_ex        <= '0;
            illegal_ex     <= 1'b0;
            data_out       <= '0;
            B_Bypass       <= '0;
            mem_en_ex      <= 1'b0;
            mem_rw_ex      <= 1'b0;
            mem_mux_sel_ex <= 1'b0;
            RW_ex          <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept && !is_mul) begin
            out_valid      <= 1'b1;
            ans_ex         <= alu_ans;
            ans_hi_ex      <= '0;
            flag_ex        <= alu_flags;
            illegal_ex     <= alu_ill;
            data_out       <= data_in;
            B_Bypass       <= B;
            mem_en_ex      <= mem_en_dec;
            mem_rw_ex      <= mem_rw_dec;
            mem_mux_sel_ex <= mem_mux_sel_dec;
            RW_ex          <= RW_dec;
`ifdef ALU_MUL_EN
        end else if (accept) begin
            out_valid <= 1'b0;
        end else if (mul_done) begin
            out_valid       <= 1'b1;
            ans_ex          <= mul_product[WIDTH-1:0];
            ans_hi_ex       <= mul_product[2*WIDTH-1:WIDTH];
            flag_ex[FLAG_Z] <= (mul_product == '0);
            flag_ex[FLAG_C] <= (mul_product[2*WIDTH-1:WIDTH] != '0);
            flag_ex[FLAG_N] <= mul_product[2*WIDTH-1];
            flag_ex[FLAG_V] <= (mul_product[2*WIDTH-1:WIDTH] != '0);
            illegal_ex      <= 1'b0;
            data_out        <= pend_data;
            B_Bypass        <= pend_b;
            mem_en_ex       <= pend_me;
            mem_rw_ex       <= pend_mr;
            mem_mux_sel_ex  <= pend_mm;
            RW_ex           <= pend_rw;
`endif
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_ex_stage.sv
// Scoreboard bench for alu_ex_stage (WIDTH=8): directed ops push expected
// results, an independent monitor pops and compares on each output handshake.
module tb_alu_ex_stage;
    import alu_ex_pkg::*;

    localparam int WIDTH   = 8;
    localparam int RW_BITS = 5;

    logic clk = 1'b0;
    logic reset, in_valid, in_ready, flush, out_valid, out_ready;
    logic [4:0] op_dec;
    logic [WIDTH-1:0] A, B, data_in, ans_ex, ans_hi_ex, data_out, B_Bypass;
    logic mem_en_dec, mem_rw_dec, mem_mux_sel_dec;
    logic mem_en_ex, mem_rw_ex, mem_mux_sel_ex;
    logic [RW_BITS-1:0] RW_dec, RW_ex;
    logic [3:0] flag_ex;
    logic illegal_ex, busy;

    always #5 clk = ~clk;

    alu_ex_stage #(.WIDTH(WIDTH), .RW_BITS(RW_BITS)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op_dec(op_dec), .A(A), .B(B), .data_in(data_in),
        .mem_en_dec(mem_en_dec), .mem_rw_dec(mem_rw_dec), .mem_mux_sel_dec(mem_mux_sel_dec),
        .RW_dec(RW_dec), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .ans_ex(ans_ex), .ans_hi_ex(ans_hi_ex), .flag_ex(flag_ex), .illegal_ex(illegal_ex),
        .data_out(data_out), .B_Bypass(B_Bypass), .mem_en_ex(mem_en_ex), .mem_rw_ex(mem_rw_ex),
        .mem_mux_sel_ex(mem_mux_sel_ex), .RW_ex(RW_ex), .busy(busy)
    );

    typedef struct packed {
        logic [7:0] ans;
        logic [7:0] hi;
        logic [3:0] flg;
        logic       ill;
        logic [7:0] dout;
        logic [7:0] bb;
        logic [2:0] mem;
        logic [4:0] rw;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   pop_idx  = 0;
    bit   seen;
    logic [4:0] kill_op;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] e_ans, input logic [7:0] e_hi, input logic [3:0] e_flg,
                        input logic e_ill, input logic [4:0] rw, input logic [2:0] mem,
                        input bit push);
        int   n;
        exp_t e;
        op_dec   = op;
        A        = a;
        B        = b;
        data_in  = a ^ b;
        RW_dec   = rw;
        {mem_en_dec, mem_rw_dec, mem_mux_sel_dec} = mem;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!in_ready) begin
            failures++;
            $display("FAIL accept_timeout op=%0d in_ready=%b want=1", op, in_ready);
        end else if (push) begin
            e = {e_ans, e_hi, e_flg, e_ill, a ^ b, b, mem, rw};
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Monitor: compare every transferred result against the head of the queue.
    always @(negedge clk) begin
        exp_t act;
        exp_t e;
        if (!reset && out_valid && out_ready) begin
            act = {ans_ex, ans_hi_ex, flag_ex, illegal_ex, data_out, B_Bypass,
                   {mem_en_ex, mem_rw_ex, mem_mux_sel_ex}, RW_ex};
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL result_unexpected got ans=%h hi=%h flags=%b want none", ans_ex, ans_hi_ex, flag_ex);
            end else begin
                e = exp_q.pop_front();
                if (act !== e) begin
                    failures++;
                    $display("FAIL result[%0d] got ans=%h hi=%h flg=%b ill=%b dout=%h bb=%h mem=%b rw=%0d want ans=%h hi=%h flg=%b ill=%b dout=%h bb=%h mem=%b rw=%0d",
                             pop_idx, act.ans, act.hi, act.flg, act.ill, act.dout, act.bb, act.mem, act.rw,
                             e.ans, e.hi, e.flg, e.ill, e.dout, e.bb, e.mem, e.rw);
                end
            end
            pop_idx++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1; in_valid = 1'b0; op_dec = '0; A = '0; B = '0; data_in = '0;
        mem_en_dec = 1'b0; mem_rw_dec = 1'b0; mem_mux_sel_dec = 1'b0; RW_dec = '0;
        flush = 1'b0; out_ready = 1'b1;
`ifdef ALU_MUL_EN
        kill_op = OP_MUL;
`else
        kill_op = OP_ADD;
`endif

        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_outputs", 64'({out_valid, ans_ex, ans_hi_ex, flag_ex, busy, illegal_ex, RW_ex}), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        //   op       A      B      ans    hi     ZCNV     ill  rw     mem
        send(OP_ADD, 8'h40, 8'hC0, 8'h00, 8'h00, 4'b1100, 1'b0, 5'd1, 3'b001, 1);
        chk("add_latency", 64'(out_valid), 64'd1);
        send(OP_SUB, 8'h40, 8'hC0, 8'h80, 8'h00, 4'b0111, 1'b0, 5'd2, 3'b010, 1);
        send(OP_ADD, 8'hFF, 8'h01, 8'h00, 8'h00, 4'b1100, 1'b0, 5'd3, 3'b100, 1);
        send(OP_ADC, 8'h01, 8'h01, 8'h03, 8'h00, 4'b0000, 1'b0, 5'd4, 3'b011, 1);
        send(OP_SHL, 8'h81, 8'h01, 8'h02, 8'h00, 4'b0100, 1'b0, 5'd5, 3'b101, 1);
        send(OP_SAR, 8'h81, 8'h02, 8'hE0, 8'h00, 4'b0010, 1'b0, 5'd6, 3'b110, 1);
        send(OP_ROR, 8'h01, 8'h01, 8'h80, 8'h00, 4'b0110, 1'b0, 5'd7, 3'b111, 1);
        send(OP_ROL, 8'hA5, 8'h08, 8'hA5, 8'h00, 4'b0010, 1'b0, 5'd8, 3'b000, 1);
        send(OP_CMP, 8'h05, 8'h05, 8'h05, 8'h00, 4'b1000, 1'b0, 5'd9, 3'b001, 1);
        send(OP_LD,  8'h10, 8'h20, 8'h30, 8'h00, 4'b1000, 1'b0, 5'd11, 3'b110, 1);
        send(5'b10101, 8'h33, 8'h44, 8'h00, 8'h00, 4'b1000, 1'b1, 5'd12, 3'b010, 1);
        send(OP_SUB, 8'h00, 8'h01, 8'hFF, 8'h00, 4'b0110, 1'b0, 5'd13, 3'b100, 1);
        send(OP_SBB, 8'h05, 8'h02, 8'h02, 8'h00, 4'b0000, 1'b0, 5'd14, 3'b001, 1);

        // Backpressure: result must hold for three cycles with the input side stalled.
        idle(1);
        out_ready = 1'b0;
        send(OP_ADD, 8'h12, 8'h34, 8'h46, 8'h00, 4'b0000, 1'b0, 5'd10, 3'b111, 1);
        repeat (3) begin
            @(negedge clk);
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_hold", 64'({ans_ex, RW_ex, mem_en_ex, mem_rw_ex, mem_mux_sel_ex}),
                64'({8'h46, 5'd10, 3'b111}));
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        idle(1);

`ifdef ALU_MUL_EN
        send(OP_MUL, 8'hC0, 8'h01, 8'hC0, 8'h00, 4'b0000, 1'b0, 5'd15, 3'b011, 1);
        for (int i = 0; i < WIDTH; i++) begin
            @(negedge clk);
            chk("mul_iterating", 64'({busy, in_ready, out_valid}), 64'(3'b100));
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("mul_latency", 64'({busy, out_valid}), 64'(2'b01));
        @(posedge clk); #1;
        send(OP_MUL, 8'hFF, 8'hFF, 8'h01, 8'hFE, 4'b0111, 1'b0, 5'd16, 3'b101, 1);
`else
        send(OP_MUL, 8'hC0, 8'h01, 8'h00, 8'h00, 4'b0000, 1'b1, 5'd15, 3'b011, 1);
        chk("mul_off_busy", 64'(busy), 64'd0);
`endif
        idle(WIDTH + 2);

        // Reset while an op is in flight.
        out_ready = 1'b0;
        send(kill_op, 8'h03, 8'h05, 8'h00, 8'h00, 4'b0000, 1'b0, 5'd17, 3'b111, 0);
`ifdef ALU_MUL_EN
        chk("kill_busy", 64'(busy), 64'd1);
`endif
        idle(2);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rst_mid_zero", 64'({out_valid, ans_ex, ans_hi_ex, flag_ex, illegal_ex, data_out, B_Bypass,
                                 mem_en_ex, mem_rw_ex, mem_mux_sel_ex, RW_ex, busy}), 64'd0);

        // Flush while an op is in flight; a new op offered during flush is not taken.
        send(kill_op, 8'h03, 8'h05, 8'h00, 8'h00, 4'b0000, 1'b0, 5'd18, 3'b111, 0);
        idle(2);
        flush    = 1'b1;
        op_dec   = OP_ADD;
        in_valid = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("flush_no_result", 64'(seen), 64'd0);
        chk("flush_busy", 64'(busy), 64'd0);
        chk("flush_flags", 64'(flag_ex), 64'd0);
        @(posedge clk); #1;

        send(OP_XOR, 8'hF0, 8'h3C, 8'hCC, 8'h00, 4'b0010, 1'b0, 5'd19, 3'b010, 1);

        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
